// File: rtl/crc_rx_checker.sv
// Receive-side CRC checker: deserialises an LSB-first data+CRC frame, recomputes
// the CRC with the transmitter's LFSR and reports data, received CRC and status.
module crc_rx_checker #(
   parameter int                   DATA_WIDTH = 8,
   parameter int                   CRC_WIDTH  = 8,
   parameter logic [CRC_WIDTH-1:0] SEED       = 8'hD8,
   parameter logic [CRC_WIDTH-1:0] TAPS       = 8'b0100_0100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ser_in,
   input  logic                  ser_valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CRC_WIDTH-1:0]  crc_out,
   output logic                  crc_ok,
   output logic                  done_tick,
   output logic                  frame_err
);

   localparam int FRAME_BITS = DATA_WIDTH + CRC_WIDTH;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   localparam logic [CNT_W-1:0] LAST_DATA_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_FRAME_BIT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CHK,
      GAP
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
   logic [CRC_WIDTH-1:0]  lfsr, lfsr_nxt;
   logic [DATA_WIDTH-1:0] data_sr, data_sr_nxt;
   logic [CRC_WIDTH-1:0]  crc_sr, crc_sr_nxt;
   logic [DATA_WIDTH-1:0] data_out_nxt;
   logic [CRC_WIDTH-1:0]  crc_out_nxt;
   logic                  crc_ok_nxt;
   logic                  done_tick_nxt;
   logic                  frame_err_nxt;
   logic                  gap_err_seen, gap_err_seen_nxt;
   logic [CRC_WIDTH-1:0]  rx_crc;

   // Bit 7 is always fed back; TAPS only selects the extra XOR points below it.
   function automatic logic [CRC_WIDTH-1:0] lfsr_step(
      input logic [CRC_WIDTH-1:0] cur,
      input logic                 d
   );
      logic fb;
      fb = d ^ cur[0];
      return {fb, cur[CRC_WIDTH-1:1]} ^
             ({CRC_WIDTH{fb}} & {1'b0, TAPS[CRC_WIDTH-2:0]});
   endfunction

   // The last CRC bit is still on ser_in when the comparison is made.
   assign rx_crc = {ser_in, crc_sr[CRC_WIDTH-1:1]};

   always_comb begin
      state_nxt        = state;
      bit_cnt_nxt      = bit_cnt;
      lfsr_nxt         = lfsr;
      data_sr_nxt      = data_sr;
      crc_sr_nxt       = crc_sr;
      data_out_nxt     = data_out;
      crc_out_nxt      = crc_out;
      crc_ok_nxt       = crc_ok;
      done_tick_nxt    = 1'b0;
      frame_err_nxt    = 1'b0;
      gap_err_seen_nxt = gap_err_seen;

      case (state)
         IDLE: begin
            lfsr_nxt         = SEED;
            bit_cnt_nxt      = '0;
            gap_err_seen_nxt = 1'b0;
            if (ser_valid) begin
               data_sr_nxt = {ser_in, data_sr[DATA_WIDTH-1:1]};
               lfsr_nxt    = lfsr_step(SEED, ser_in);
               bit_cnt_nxt = CNT_W'(1);
               state_nxt   = DATA;
            end
         end

         DATA: begin
            if (ser_valid) begin
               data_sr_nxt = {ser_in, data_sr[DATA_WIDTH-1:1]};
               lfsr_nxt    = lfsr_step(lfsr, ser_in);
               bit_cnt_nxt = bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_DATA_BIT) begin
                  state_nxt = CHK;
               end
            end else begin
               frame_err_nxt = 1'b1;
               lfsr_nxt      = SEED;
               bit_cnt_nxt   = '0;
               state_nxt     = IDLE;
            end
         end

         CHK: begin
            if (ser_valid) begin
               crc_sr_nxt  = rx_crc;
               bit_cnt_nxt = bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_FRAME_BIT) begin
                  data_out_nxt     = data_sr;
                  crc_out_nxt      = rx_crc;
                  crc_ok_nxt       = (rx_crc == lfsr);
                  done_tick_nxt    = 1'b1;
                  bit_cnt_nxt      = '0;
                  gap_err_seen_nxt = 1'b0;
                  state_nxt        = GAP;
               end
            end else begin
               frame_err_nxt = 1'b1;
               lfsr_nxt      = SEED;
               bit_cnt_nxt   = '0;
               state_nxt     = IDLE;
            end
         end

         GAP: begin
            if (!ser_valid) begin
               lfsr_nxt  = SEED;
               state_nxt = IDLE;
            end else if (!gap_err_seen) begin
               frame_err_nxt    = 1'b1;
               gap_err_seen_nxt = 1'b1;
            end
         end

         default: begin
            lfsr_nxt    = SEED;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         lfsr         <= SEED;
         data_sr      <= '0;
         crc_sr       <= '0;
         data_out     <= '0;
         crc_out      <= '0;
         crc_ok       <= 1'b0;
         done_tick    <= 1'b0;
         frame_err    <= 1'b0;
         gap_err_seen <= 1'b0;
      end else begin
         state        <= state_nxt;
         bit_cnt      <= bit_cnt_nxt;
         lfsr         <= lfsr_nxt;
         data_sr      <= data_sr_nxt;
         crc_sr       <= crc_sr_nxt;
         data_out     <= data_out_nxt;
         crc_out      <= crc_out_nxt;
         crc_ok       <= crc_ok_nxt;
         done_tick    <= done_tick_nxt;
         frame_err    <= frame_err_nxt;
         gap_err_seen <= gap_err_seen_nxt;
      end
   end

endmodule

// File: tb/tb_crc_rx_checker.sv
// Directed bench for crc_rx_checker: good/bad CRC frames, short, overlong,
// mid-frame reset and back-to-back frames with hand-computed CRC bytes.
module tb_crc_rx_checker;

   logic       clk;
   logic       rst;
   logic       ser_in;
   logic       ser_valid;
   logic [7:0] data_out;
   logic [7:0] crc_out;
   logic       crc_ok;
   logic       done_tick;
   logic       frame_err;

   int n_checks;
   int n_pass;
   int done_cnt;
   int err_cnt;

   crc_rx_checker dut (
      .clk       (clk),
      .rst       (rst),
      .ser_in    (ser_in),
      .ser_valid (ser_valid),
      .data_out  (data_out),
      .crc_out   (crc_out),
      .crc_ok    (crc_ok),
      .done_tick (done_tick),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle, well away from the active edge.
   always @(negedge clk) begin
      if (done_tick) done_cnt++;
      if (frame_err) err_cnt++;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends bits[0..n-1] LSB first with ser_valid high; leaves ser_valid high.
   task automatic applyStimulus(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ser_in    = bits[i];
         ser_valid = 1'b1;
         step(1);
      end
   endtask

   task automatic idle(input int n);
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      step(n);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      n_checks++; if (data_out !== 8'h00) $display("[TB] FAIL reset_data got %h exp 00", data_out); else n_pass++;
      n_checks++; if (crc_out !== 8'h00) $display("[TB] FAIL reset_crc got %h exp 00", crc_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b0) $display("[TB] FAIL reset_ok got %b exp 0", crc_ok); else n_pass++;
      n_checks++; if (done_tick !== 1'b0) $display("[TB] FAIL reset_done got %b exp 0", done_tick); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_err got %b exp 0", frame_err); else n_pass++;
   endtask

   task automatic test_good_frames;
      applyStimulus(32'h0000_1400, 16);
      n_checks++; if (done_tick !== 1'b1) $display("[TB] FAIL f00_done got %b exp 1", done_tick); else n_pass++;
      n_checks++; if (data_out !== 8'h00) $display("[TB] FAIL f00_data got %h exp 00", data_out); else n_pass++;
      n_checks++; if (crc_out !== 8'h14) $display("[TB] FAIL f00_crc got %h exp 14", crc_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b1) $display("[TB] FAIL f00_ok got %b exp 1", crc_ok); else n_pass++;
      idle(1);
      n_checks++; if (done_tick !== 1'b0) $display("[TB] FAIL f00_done_width got %b exp 0", done_tick); else n_pass++;
      idle(1);
      applyStimulus(32'h0000_72FF, 16);
      n_checks++; if (done_tick !== 1'b1) $display("[TB] FAIL fff_done got %b exp 1", done_tick); else n_pass++;
      n_checks++; if (data_out !== 8'hFF) $display("[TB] FAIL fff_data got %h exp ff", data_out); else n_pass++;
      n_checks++; if (crc_out !== 8'h72) $display("[TB] FAIL fff_crc got %h exp 72", crc_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b1) $display("[TB] FAIL fff_ok got %b exp 1", crc_ok); else n_pass++;
      idle(2);
      applyStimulus(32'h0000_73FF, 16);
      n_checks++; if (done_tick !== 1'b1) $display("[TB] FAIL bad_done got %b exp 1", done_tick); else n_pass++;
      n_checks++; if (crc_out !== 8'h73) $display("[TB] FAIL bad_crc got %h exp 73", crc_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b0) $display("[TB] FAIL bad_ok got %b exp 0", crc_ok); else n_pass++;
      idle(2);
   endtask

   task automatic test_short_frame;
      done_cnt = 0;
      err_cnt  = 0;
      applyStimulus(32'h0000_1400, 11);
      idle(1);
      n_checks++; if (frame_err !== 1'b1) $display("[TB] FAIL short_err got %b exp 1", frame_err); else n_pass++;
      n_checks++; if (done_tick !== 1'b0) $display("[TB] FAIL short_done got %b exp 0", done_tick); else n_pass++;
      n_checks++; if (data_out !== 8'hFF) $display("[TB] FAIL short_data got %h exp ff", data_out); else n_pass++;
      n_checks++; if (crc_out !== 8'h73) $display("[TB] FAIL short_crc got %h exp 73", crc_out); else n_pass++;
      idle(1);
      n_checks++; if (frame_err !== 1'b0) $display("[TB] FAIL short_err_width got %b exp 0", frame_err); else n_pass++;
      n_checks++; if (err_cnt !== 1 || done_cnt !== 0) $display("[TB] FAIL short_pulses got err=%0d done=%0d exp err=1 done=0", err_cnt, done_cnt); else n_pass++;
      applyStimulus(32'h0000_1400, 16);
      n_checks++; if (done_tick !== 1'b1) $display("[TB] FAIL reseed_done got %b exp 1", done_tick); else n_pass++;
      n_checks++; if (data_out !== 8'h00) $display("[TB] FAIL reseed_data got %h exp 00", data_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b1) $display("[TB] FAIL reseed_ok got %b exp 1", crc_ok); else n_pass++;
      idle(2);
   endtask

   task automatic test_overlong;
      done_cnt = 0;
      err_cnt  = 0;
      applyStimulus(32'h0000_72FF, 16);
      n_checks++; if (done_tick !== 1'b1) $display("[TB] FAIL long_done got %b exp 1", done_tick); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("[TB] FAIL long_err_early got %b exp 0", frame_err); else n_pass++;
      applyStimulus(32'h0000_0001, 1);
      n_checks++; if (frame_err !== 1'b1) $display("[TB] FAIL long_err got %b exp 1", frame_err); else n_pass++;
      n_checks++; if (done_tick !== 1'b0) $display("[TB] FAIL long_done_width got %b exp 0", done_tick); else n_pass++;
      applyStimulus(32'h0000_0005, 3);
      n_checks++; if (frame_err !== 1'b0) $display("[TB] FAIL long_err_width got %b exp 0", frame_err); else n_pass++;
      idle(2);
      n_checks++; if (err_cnt !== 1 || done_cnt !== 1) $display("[TB] FAIL long_pulses got err=%0d done=%0d exp err=1 done=1", err_cnt, done_cnt); else n_pass++;
      n_checks++; if (data_out !== 8'hFF) $display("[TB] FAIL long_data got %h exp ff", data_out); else n_pass++;
      n_checks++; if (crc_out !== 8'h72) $display("[TB] FAIL long_crc got %h exp 72", crc_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b1) $display("[TB] FAIL long_ok got %b exp 1", crc_ok); else n_pass++;
   endtask

   task automatic test_reset_mid_frame;
      done_cnt = 0;
      err_cnt  = 0;
      applyStimulus(32'h0000_72FF, 6);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      n_checks++; if (data_out !== 8'h00) $display("[TB] FAIL mid_rst_data got %h exp 00", data_out); else n_pass++;
      n_checks++; if (crc_out !== 8'h00) $display("[TB] FAIL mid_rst_crc got %h exp 00", crc_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b0) $display("[TB] FAIL mid_rst_ok got %b exp 0", crc_ok); else n_pass++;
      idle(2);
      n_checks++; if (err_cnt !== 0 || done_cnt !== 0) $display("[TB] FAIL mid_rst_pulses got err=%0d done=%0d exp err=0 done=0", err_cnt, done_cnt); else n_pass++;
      applyStimulus(32'h0000_1400, 16);
      n_checks++; if (done_tick !== 1'b1) $display("[TB] FAIL post_rst_done got %b exp 1", done_tick); else n_pass++;
      n_checks++; if (crc_out !== 8'h14) $display("[TB] FAIL post_rst_crc got %h exp 14", crc_out); else n_pass++;
      n_checks++; if (crc_ok !== 1'b1) $display("[TB] FAIL post_rst_ok got %b exp 1", crc_ok); else n_pass++;
      idle(2);
   endtask

   task automatic test_back_to_back;
      done_cnt = 0;
      err_cnt  = 0;
      applyStimulus(32'h0000_1400, 16);
      n_checks++; if (done_tick !== 1'b1 || crc_ok !== 1'b1) $display("[TB] FAIL b2b_first got done=%b ok=%b exp 1 1", done_tick, crc_ok); else n_pass++;
      idle(1);
      applyStimulus(32'h0000_72FF, 16);
      n_checks++; if (done_tick !== 1'b1 || crc_ok !== 1'b1) $display("[TB] FAIL b2b_second got done=%b ok=%b exp 1 1", done_tick, crc_ok); else n_pass++;
      n_checks++; if (data_out !== 8'hFF) $display("[TB] FAIL b2b_data got %h exp ff", data_out); else n_pass++;
      idle(2);
      n_checks++; if (done_cnt !== 2 || err_cnt !== 0) $display("[TB] FAIL b2b_pulses got done=%0d err=%0d exp done=2 err=0", done_cnt, err_cnt); else n_pass++;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      done_cnt  = 0;
      err_cnt   = 0;
      rst       = 1'b1;
      ser_in    = 1'b0;
      ser_valid = 1'b0;
      #2;
      test_reset();
      test_good_frames();
      test_short_frame();
      test_overlong();
      test_reset_mid_frame();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
